// File: rtl/pact_lsu_stream_node.sv
// PACT LSU stream node: moves `count` words between the move-register port and one
// AXI master using INCR bursts (contiguous or strided), buffered through a data FIFO.
module pact_lsu_stream_node #(
    parameter int BW_ADDR     = 32,
    parameter int BW_AXI_DATA = 32,
    parameter int BW_AXI_TID  = 4,
    parameter int BW_COUNT    = 16,
    parameter int MAX_BURST   = 16,
    parameter int FIFO_DEPTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [1:0]             subop,
    input  logic [BW_ADDR-1:0]     cmd_addr,
    input  logic [BW_COUNT-1:0]    cmd_count,
    input  logic [BW_ADDR-1:0]     cmd_stride,
    output logic                   busy,
    output logic                   finish,
    output logic                   error,
    input  logic                   rreg_sme,
    output logic                   rreg_smvalid,
    output logic [BW_AXI_DATA-1:0] rreg_smvalue,
    input  logic                   wreg_rme,
    output logic                   wreg_rmready,
    input  logic [BW_AXI_DATA-1:0] wreg_rmvalue,
    output logic [BW_AXI_TID-1:0]  dma_sxarid,
    output logic [BW_ADDR-1:0]     dma_sxaraddr,
    output logic [7:0]             dma_sxarlen,
    output logic [2:0]             dma_sxarsize,
    output logic [1:0]             dma_sxarburst,
    output logic                   dma_sxarlock,
    output logic [3:0]             dma_sxarcache,
    output logic [2:0]             dma_sxarprot,
    output logic                   dma_sxarvalid,
    input  logic                   dma_sxarready,
    input  logic [BW_AXI_TID-1:0]  dma_sxrid,
    input  logic [BW_AXI_DATA-1:0] dma_sxrdata,
    input  logic [1:0]             dma_sxrresp,
    input  logic                   dma_sxrlast,
    input  logic                   dma_sxrvalid,
    output logic                   dma_sxrready,
    output logic [BW_AXI_TID-1:0]  dma_sxawid,
    output logic [BW_ADDR-1:0]     dma_sxawaddr,
    output logic [7:0]             dma_sxawlen,
    output logic [2:0]             dma_sxawsize,
    output logic [1:0]             dma_sxawburst,
    output logic                   dma_sxawlock,
    output logic [3:0]             dma_sxawcache,
    output logic [2:0]             dma_sxawprot,
    output logic                   dma_sxawvalid,
    input  logic                   dma_sxawready,
    output logic [BW_AXI_DATA-1:0] dma_sxwdata,
    output logic [BW_AXI_DATA/8-1:0] dma_sxwstrb,
    output logic                   dma_sxwlast,
    output logic                   dma_sxwvalid,
    input  logic                   dma_sxwready,
    input  logic [BW_AXI_TID-1:0]  dma_sxbid,
    input  logic [1:0]             dma_sxbresp,
    input  logic                   dma_sxbvalid,
    output logic                   dma_sxbready
);
    localparam int BYTES = BW_AXI_DATA / 8;
    localparam int SZ    = $clog2(BYTES);
    localparam int LW    = $clog2(MAX_BURST) + 1;
    localparam int AW    = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_CALC, S_ADDR, S_DATA, S_RESP, S_DONE} state_t;

    state_t               state_q, state_d;
    logic                 store_q, store_d, strided_q, strided_d;
    logic [BW_ADDR-1:0]   addr_q, addr_d, stride_q, stride_d;
    logic [BW_COUNT-1:0]  count_q, count_d, rem_q, rem_d, push_cnt_q, push_cnt_d;
    logic [LW-1:0]        len_q, len_d, beat_q, beat_d, len_calc;
    logic                 error_q, error_d, finish_q, finish_d;

    logic [BW_AXI_DATA-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]          wptr_q, rptr_q;
    logic [AW:0]            cnt_q;
    logic                   fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic                   r_hs, w_hs, last_beat, burst_done;
    logic [12:0]            to_bound;
    logic [31:0]            l_tmp;
    logic                   unused_axi;

    assign fifo_full  = (cnt_q == (AW+1)'(FIFO_DEPTH));
    assign fifo_empty = (cnt_q == '0);
    assign last_beat  = (beat_q == len_q - LW'(1));

    // Load issue is gated on free space (credit), store issue on buffered data.
    assign dma_sxarvalid = (state_q == S_ADDR) && !store_q &&
                           ((32'(FIFO_DEPTH) - 32'(cnt_q)) >= 32'(len_q));
    assign dma_sxawvalid = (state_q == S_ADDR) && store_q && (32'(cnt_q) >= 32'(len_q));
    assign dma_sxrready  = (state_q == S_DATA) && !store_q;
    assign dma_sxwvalid  = (state_q == S_DATA) && store_q && !fifo_empty;
    assign dma_sxbready  = (state_q == S_RESP);
    assign r_hs          = dma_sxrvalid && dma_sxrready;
    assign w_hs          = dma_sxwvalid && dma_sxwready;

    assign dma_sxarid    = '0;
    assign dma_sxaraddr  = addr_q;
    assign dma_sxarlen   = 8'(len_q - LW'(1));
    assign dma_sxarsize  = 3'(SZ);
    assign dma_sxarburst = 2'b01;
    assign dma_sxarlock  = 1'b0;
    assign dma_sxarcache = 4'b0000;
    assign dma_sxarprot  = 3'b000;
    assign dma_sxawid    = '0;
    assign dma_sxawaddr  = addr_q;
    assign dma_sxawlen   = 8'(len_q - LW'(1));
    assign dma_sxawsize  = 3'(SZ);
    assign dma_sxawburst = 2'b01;
    assign dma_sxawlock  = 1'b0;
    assign dma_sxawcache = 4'b0000;
    assign dma_sxawprot  = 3'b000;
    assign dma_sxwdata   = fifo_mem[rptr_q];
    assign dma_sxwstrb   = '1;
    assign dma_sxwlast   = last_beat;

    assign busy          = (state_q != S_IDLE);
    assign finish        = finish_q;
    assign error         = error_q;
    assign rreg_smvalid  = !store_q && !fifo_empty;
    assign rreg_smvalue  = fifo_mem[rptr_q];
    assign wreg_rmready  = busy && store_q && !fifo_full;

    assign fifo_push = store_q ? (wreg_rme && busy && (push_cnt_q < count_q) && (!fifo_full || fifo_pop))
                               : r_hs;
    assign fifo_pop  = store_q ? w_hs : (rreg_sme && !fifo_empty);
    assign unused_axi = ^{dma_sxrid, dma_sxrlast, dma_sxbid};

    // Burst length: bounded by remaining words, MAX_BURST and the next 4 KB page.
    assign to_bound = 13'h1000 - {1'b0, addr_q[11:0]};
    always_comb begin
        l_tmp = 32'(rem_q);
        if (l_tmp > 32'(MAX_BURST)) l_tmp = 32'(MAX_BURST);
        if (l_tmp > 32'(to_bound >> SZ)) l_tmp = 32'(to_bound >> SZ);
        if (strided_q) l_tmp = 32'd1;
        len_calc = LW'(l_tmp);
    end

    always_comb begin
        state_d    = state_q;
        store_d    = store_q;
        strided_d  = strided_q;
        addr_d     = addr_q;
        stride_d   = stride_q;
        count_d    = count_q;
        rem_d      = rem_q;
        push_cnt_d = push_cnt_q;
        len_d      = len_q;
        beat_d     = beat_q;
        error_d    = error_q;
        finish_d   = 1'b0;
        burst_done = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                store_d    = subop[0];
                strided_d  = subop[1];
                addr_d     = cmd_addr & ~BW_ADDR'(BYTES - 1);
                stride_d   = cmd_stride;
                count_d    = cmd_count;
                rem_d      = cmd_count;
                push_cnt_d = '0;
                error_d    = 1'b0;
                state_d    = (cmd_count == '0) ? S_DONE : S_CALC;
            end
            S_CALC: begin
                len_d   = len_calc;
                beat_d  = '0;
                state_d = S_ADDR;
            end
            S_ADDR: if ((dma_sxarvalid && dma_sxarready) || (dma_sxawvalid && dma_sxawready))
                state_d = S_DATA;
            S_DATA: if (r_hs || w_hs) begin
                beat_d = beat_q + LW'(1);
                if (r_hs && dma_sxrresp != 2'b00) error_d = 1'b1;
                if (last_beat) begin
                    if (store_q) state_d = S_RESP;
                    else         burst_done = 1'b1;
                end
            end
            S_RESP: if (dma_sxbvalid) begin
                if (dma_sxbresp != 2'b00) error_d = 1'b1;
                burst_done = 1'b1;
            end
            S_DONE: if (store_q || fifo_empty) begin
                finish_d = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (burst_done) begin
            rem_d   = rem_q - BW_COUNT'(len_q);
            addr_d  = strided_q ? addr_q + stride_q : addr_q + (BW_ADDR'(len_q) << SZ);
            state_d = (rem_q == BW_COUNT'(len_q)) ? S_DONE : S_CALC;
        end
        if (fifo_push && store_q) push_cnt_d = push_cnt_q + BW_COUNT'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            store_q    <= 1'b0;
            strided_q  <= 1'b0;
            addr_q     <= '0;
            stride_q   <= '0;
            count_q    <= '0;
            rem_q      <= '0;
            push_cnt_q <= '0;
            len_q      <= '0;
            beat_q     <= '0;
            error_q    <= 1'b0;
            finish_q   <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            store_q    <= store_d;
            strided_q  <= strided_d;
            addr_q     <= addr_d;
            stride_q   <= stride_d;
            count_q    <= count_d;
            rem_q      <= rem_d;
            push_cnt_q <= push_cnt_d;
            len_q      <= len_d;
            beat_q     <= beat_d;
            error_q    <= error_d;
            finish_q   <= finish_d;
            if (fifo_push) wptr_q <= wptr_q + AW'(1);
            if (fifo_pop)  rptr_q <= rptr_q + AW'(1);
            case ({fifo_push, fifo_pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage carries no reset; dropping the pointers discards the contents.
    always_ff @(posedge clk) begin
        if (fifo_push) fifo_mem[wptr_q] <= store_q ? wreg_rmvalue : dma_sxrdata;
    end
endmodule

// File: tb/tb_pact_lsu_stream_node.sv
// Scoreboard bench for pact_lsu_stream_node: a reactive AXI slave plus monitor pops
// expected AR/AW/W/read-data entries queued by the directed stimulus.
module tb_pact_lsu_stream_node;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  subop = '0;
    logic [31:0] cmd_addr = '0, cmd_stride = '0;
    logic [15:0] cmd_count = '0;
    logic        busy, finish, error;
    logic        rreg_sme = 1'b0, rreg_smvalid;
    logic [31:0] rreg_smvalue;
    logic        wreg_rme = 1'b0, wreg_rmready;
    logic [31:0] wreg_rmvalue = '0;
    logic [3:0]  arid, awid;
    logic [31:0] araddr, awaddr, wdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic [1:0]  arburst, awburst;
    logic        arlock, awlock;
    logic [3:0]  arcache, awcache, wstrb;
    logic        arvalid, awvalid, wvalid, wlast, rready, bready;
    logic        arready = 1'b0, awready = 1'b0, wready = 1'b0;
    logic        rvalid = 1'b0, rlast = 1'b0, bvalid = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0, bresp = '0;

    always #5 clk = ~clk;

    pact_lsu_stream_node dut (
        .clk(clk), .rst(rst), .start(start), .subop(subop), .cmd_addr(cmd_addr),
        .cmd_count(cmd_count), .cmd_stride(cmd_stride), .busy(busy), .finish(finish),
        .error(error), .rreg_sme(rreg_sme), .rreg_smvalid(rreg_smvalid),
        .rreg_smvalue(rreg_smvalue), .wreg_rme(wreg_rme), .wreg_rmready(wreg_rmready),
        .wreg_rmvalue(wreg_rmvalue),
        .dma_sxarid(arid), .dma_sxaraddr(araddr), .dma_sxarlen(arlen), .dma_sxarsize(arsize),
        .dma_sxarburst(arburst), .dma_sxarlock(arlock), .dma_sxarcache(arcache),
        .dma_sxarprot(arprot), .dma_sxarvalid(arvalid), .dma_sxarready(arready),
        .dma_sxrid(4'd0), .dma_sxrdata(rdata), .dma_sxrresp(rresp), .dma_sxrlast(rlast),
        .dma_sxrvalid(rvalid), .dma_sxrready(rready),
        .dma_sxawid(awid), .dma_sxawaddr(awaddr), .dma_sxawlen(awlen), .dma_sxawsize(awsize),
        .dma_sxawburst(awburst), .dma_sxawlock(awlock), .dma_sxawcache(awcache),
        .dma_sxawprot(awprot), .dma_sxawvalid(awvalid), .dma_sxawready(awready),
        .dma_sxwdata(wdata), .dma_sxwstrb(wstrb), .dma_sxwlast(wlast), .dma_sxwvalid(wvalid),
        .dma_sxwready(wready), .dma_sxbid(4'd0), .dma_sxbresp(bresp), .dma_sxbvalid(bvalid),
        .dma_sxbready(bready)
    );

    int total = 0, passed = 0;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] mword(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[15:0]};
    endfunction

    logic [39:0] exp_ar[$], exp_aw[$], rq[$];
    logic [32:0] exp_w[$];
    logic [31:0] exp_rd[$];
    int  r_beat = 0, b_pend = 0, err_beat = -1;
    int  r_cnt = 0, b_cnt = 0, fin_cnt = 0, fin_b = 0, valid_cnt = 0;
    bit  ar_f = 0, r_f = 0, w_f = 0, wl_f = 0, b_f = 0, consume = 0, w_stall = 0;
    logic [39:0] ar_word;

    // Slave + monitor: commit last edge's handshakes, drive, then evaluate the next edge.
    always @(negedge clk) begin
        if (rst) begin
            rq.delete(); exp_ar.delete(); exp_aw.delete(); exp_w.delete(); exp_rd.delete();
            r_beat = 0; b_pend = 0; ar_f = 0; r_f = 0; w_f = 0; wl_f = 0; b_f = 0;
            rvalid = 0; bvalid = 0; rreg_sme = 0;
        end else begin
            if (ar_f) rq.push_back(ar_word);
            if (r_f) begin
                r_cnt++; r_beat++;
                if (r_beat > int'(rq[0][39:32])) begin void'(rq.pop_front()); r_beat = 0; end
            end
            if (w_f && wl_f) b_pend++;
            if (b_f) begin b_pend--; b_cnt++; end
            arready = 1; awready = 1; wready = !w_stall;
            bvalid = (b_pend > 0); bresp = 2'b00;
            rvalid = (rq.size() > 0);
            if (rvalid) begin
                rdata = mword(rq[0][31:0] + 32'(r_beat * 4));
                rresp = (r_cnt == err_beat) ? 2'b10 : 2'b00;
                rlast = (r_beat == int'(rq[0][39:32]));
            end
            rreg_sme = consume;
            ar_f = arvalid && arready;
            if (ar_f) begin
                ar_word = {arlen, araddr};
                chk("ar_pending", exp_ar.size() != 0, 1);
                if (exp_ar.size() != 0) chk("ar_len_addr", ar_word, exp_ar.pop_front());
                chk("ar_size_burst", {arsize, arburst}, {3'd2, 2'b01});
            end
            if (awvalid && awready) begin
                chk("aw_pending", exp_aw.size() != 0, 1);
                if (exp_aw.size() != 0) chk("aw_len_addr", {awlen, awaddr}, exp_aw.pop_front());
            end
            r_f = rvalid && rready;
            w_f = wvalid && wready; wl_f = wlast;
            if (w_f) begin
                chk("w_pending", exp_w.size() != 0, 1);
                if (exp_w.size() != 0) chk("w_last_data", {wlast, wdata}, exp_w.pop_front());
            end
            b_f = bvalid && bready;
            if (rreg_smvalid && rreg_sme) begin
                chk("rd_pending", exp_rd.size() != 0, 1);
                if (exp_rd.size() != 0) chk("rd_data", rreg_smvalue, exp_rd.pop_front());
            end
            if (finish) begin fin_cnt++; fin_b = b_cnt; end
            if (arvalid || awvalid || wvalid) valid_cnt++;
        end
    end

    task automatic tick();
        @(negedge clk); #1;
    endtask

    task automatic issue(input logic [1:0] so, input logic [31:0] a, input logic [15:0] c,
                         input logic [31:0] s);
        tick(); start = 1; subop = so; cmd_addr = a; cmd_count = c; cmd_stride = s;
        tick(); start = 0;
    endtask

    task automatic wait_finish(input string name, input int budget);
        int f0 = fin_cnt;
        int n = 0;
        while (fin_cnt == f0 && n < budget) begin tick(); n++; end
        chk(name, fin_cnt - f0, 1);
    endtask

    task automatic push(input logic [31:0] v);
        int n = 0;
        wreg_rmvalue = v; wreg_rme = 1;
        while (!wreg_rmready && n < 50) begin tick(); n++; end
        chk("push_ready", wreg_rmready, 1);
        tick(); wreg_rme = 0;
    endtask

    initial begin
        int r0, v0, f0, b0, n;
        #2 rst = 1;
        repeat (3) tick();
        chk("rst_status", {busy, finish, error, rreg_smvalid, wreg_rmready}, 5'b0);
        chk("rst_axi", {arvalid, awvalid, wvalid, rready, bready}, 5'b0);
        rst = 0;
        tick();

        // Contiguous load of 20 words: 16 + 4 beats.
        consume = 1;
        exp_ar.push_back({8'd15, 32'h1000}); exp_ar.push_back({8'd3, 32'h1040});
        for (int i = 0; i < 20; i++) exp_rd.push_back(mword(32'h1000 + 32'(i * 4)));
        issue(2'b00, 32'h1000, 16'd20, 32'h0);
        chk("load20_busy", busy, 1);
        wait_finish("load20_finish", 300);
        chk("load20_idle", {busy, rreg_smvalid}, 2'b00);
        chk("load20_drained", exp_rd.size() + exp_ar.size(), 0);

        // 4 KB page crossing splits into two 2-beat bursts.
        exp_ar.push_back({8'd1, 32'h0FF8}); exp_ar.push_back({8'd1, 32'h1000});
        for (int i = 0; i < 4; i++) exp_rd.push_back(mword(32'h0FF8 + 32'(i * 4)));
        issue(2'b00, 32'h0FF8, 16'd4, 32'h0);
        wait_finish("cross4k_finish", 200);
        chk("cross4k_drained", exp_rd.size() + exp_ar.size(), 0);

        // Credit: idle consumer stalls issue after 32 beats.
        consume = 0; r0 = r_cnt;
        for (int i = 0; i < 4; i++) exp_ar.push_back({8'd15, 32'h3000 + 32'(i * 64)});
        for (int i = 0; i < 64; i++) exp_rd.push_back(mword(32'h3000 + 32'(i * 4)));
        issue(2'b00, 32'h3000, 16'd64, 32'h0);
        repeat (150) tick();
        chk("credit_beats", r_cnt - r0, 32);
        chk("credit_stalled", {arvalid, busy, rreg_smvalid}, 3'b011);
        chk("credit_ar_left", exp_ar.size(), 2);
        consume = 1;
        wait_finish("credit_finish", 600);
        chk("credit_total", r_cnt - r0, 64);
        chk("credit_drained", exp_rd.size(), 0);

        // SLVERR on the second beat; error sticky until the next start.
        err_beat = r_cnt + 1;
        exp_ar.push_back({8'd3, 32'h4000});
        for (int i = 0; i < 4; i++) exp_rd.push_back(mword(32'h4000 + 32'(i * 4)));
        issue(2'b00, 32'h4000, 16'd4, 32'h0);
        chk("err_clear_at_start", error, 0);
        wait_finish("err_finish", 200);
        chk("err_sticky", error, 1);
        err_beat = -1;

        // count = 0: finish two cycles after start, no AXI traffic.
        v0 = valid_cnt;
        tick(); start = 1; subop = 2'b00; cmd_addr = 32'h6000; cmd_count = 16'd0;
        tick(); start = 0;
        chk("zero_cyc1", {busy, finish, error}, 3'b100);
        tick();
        chk("zero_cyc2", {busy, finish}, 2'b01);
        tick();
        chk("zero_after", {busy, finish}, 2'b00);
        chk("zero_no_axi", valid_cnt - v0, 0);

        // Reset in the middle of a store data phase.
        w_stall = 1;
        exp_aw.push_back({8'd3, 32'h5000});
        issue(2'b01, 32'h5000, 16'd4, 32'h0);
        for (int i = 0; i < 4; i++) push(32'hD000_0000 + 32'(i));
        n = 0;
        while (!wvalid && n < 50) begin tick(); n++; end
        chk("rstmid_in_data", wvalid, 1);
        f0 = fin_cnt;
        #2 rst = 1;
        #1 chk("rstmid_async", {busy, finish, wvalid, awvalid, wreg_rmready, bready, rready}, 7'b0);
        tick(); tick();
        w_stall = 0; rst = 0;
        tick();
        chk("rstmid_no_finish", fin_cnt - f0, 0);

        // Strided store of three words after the reset.
        b0 = b_cnt;
        exp_aw.push_back({8'd0, 32'h2000}); exp_aw.push_back({8'd0, 32'h2100});
        exp_aw.push_back({8'd0, 32'h2200});
        exp_w.push_back({1'b1, 32'hAAAA_0001}); exp_w.push_back({1'b1, 32'hBBBB_0002});
        exp_w.push_back({1'b1, 32'hCCCC_0003});
        issue(2'b11, 32'h2000, 16'd3, 32'h100);
        push(32'hAAAA_0001); push(32'hBBBB_0002); push(32'hCCCC_0003);
        wait_finish("stride_finish", 200);
        chk("stride_b_before_finish", fin_b - b0, 3);
        chk("stride_drained", exp_aw.size() + exp_w.size(), 0);
        repeat (3) tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
